// File: rtl/dep_dispatch_ctrl.sv
// dep_dispatch_ctrl: serialises one engine's instructions against dependency token counters.
module dep_dispatch_ctrl #(
  parameter int INST_W = 128,
  parameter int NUM_DEP = 3,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [INST_W-1:0]        inst_payload,
  input  logic [NUM_DEP-1:0]       inst_wait,
  input  logic [NUM_DEP-1:0]       inst_release,
  input  logic                     inst_last,
  input  logic [NUM_DEP*CNT_W-1:0] dep_count,
  output logic [NUM_DEP-1:0]       dep_consume,
  output logic [NUM_DEP-1:0]       dep_release,
  output logic                     exec_start,
  output logic [INST_W-1:0]        exec_inst,
  input  logic                     exec_done,
  output logic                     busy,
  output logic                     prog_done,
  output logic [31:0]              wait_cycles
);
  typedef enum logic [2:0] {IDLE, WAIT_DEP, ISSUE, EXEC, RELEASE} state_t;
  state_t state, state_n;
  logic [NUM_DEP-1:0] wait_q, rel_q, blk;
  logic last_q;
  // A channel is available only when its signed count is strictly positive.
  for (genvar i = 0; i < NUM_DEP; i++) begin : g_blk
    assign blk[i] = wait_q[i] && (dep_count[i*CNT_W+CNT_W-1] || ~|dep_count[i*CNT_W +: CNT_W]);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = inst_valid ? WAIT_DEP : IDLE;
      WAIT_DEP: state_n = |blk ? WAIT_DEP : ISSUE;
      ISSUE:    state_n = EXEC;
      EXEC:     state_n = exec_done ? RELEASE : EXEC;
      RELEASE:  state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_q      <= '0;
      rel_q       <= '0;
      last_q      <= 1'b0;
      exec_inst   <= '0;
      wait_cycles <= '0;
      prog_done   <= 1'b0;
      inst_ready  <= 1'b0;
      busy        <= 1'b0;
      exec_start  <= 1'b0;
      dep_consume <= '0;
      dep_release <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && inst_valid) begin
        exec_inst <= inst_payload;
        wait_q    <= inst_wait;
        rel_q     <= inst_release;
        last_q    <= inst_last;
        prog_done <= 1'b0;
      end
      if (state == WAIT_DEP && |blk && wait_cycles != '1) wait_cycles <= wait_cycles + 32'd1;
      if (state_n == RELEASE && last_q) prog_done <= 1'b1;
      inst_ready  <= state_n == IDLE;
      busy        <= state_n != IDLE;
      exec_start  <= state_n == ISSUE;
      dep_consume <= state_n == ISSUE ? wait_q : '0;
      dep_release <= state_n == RELEASE ? rel_q : '0;
    end
  end
endmodule

// File: tb/tb_dep_dispatch_ctrl.sv
// tb_dep_dispatch_ctrl: scoreboard bench for dep_dispatch_ctrl.
module tb_dep_dispatch_ctrl;
  logic clk = 0, reset = 1;
  logic inst_valid = 0, inst_last = 0, exec_done = 0;
  logic inst_ready, exec_start, busy, prog_done;
  logic [127:0] inst_payload = '0, exec_inst;
  logic [2:0] inst_wait = '0, inst_release = '0, dep_consume, dep_release;
  logic [95:0] dep_count = '0;
  logic [31:0] wait_cycles;
  typedef struct {logic [127:0] p; logic [2:0] w; logic [2:0] r; logic last;} exp_t;
  exp_t q[$];
  exp_t pend;
  int n_chk = 0, n_pass = 0, wc_exp = 0, n;
  bit exec_phase = 0, rel_due = 0, prog_exp = 0;
  dep_dispatch_ctrl dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_payload(inst_payload), .inst_wait(inst_wait), .inst_release(inst_release),
    .inst_last(inst_last), .dep_count(dep_count), .dep_consume(dep_consume),
    .dep_release(dep_release), .exec_start(exec_start), .exec_inst(exec_inst),
    .exec_done(exec_done), .busy(busy), .prog_done(prog_done), .wait_cycles(wait_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic set_cnt(input int i, input logic [31:0] v);
    dep_count[i*32 +: 32] = v;
  endtask
  task automatic send(input logic [2:0] w, input logic [2:0] r, input logic last);
    exp_t e;
    int k = 0;
    while (!inst_ready && k < 100) begin tick(); k++; end
    if (!inst_ready) begin chk("ready_timeout", 0, 1); return; end
    e.p = {$urandom(), $urandom(), $urandom(), $urandom()};
    e.w = w; e.r = r; e.last = last;
    q.push_back(e);
    prog_exp = 0;
    inst_valid = 1; inst_payload = e.p; inst_wait = w; inst_release = r; inst_last = last;
    tick();
    inst_valid = 0; inst_payload = '0; inst_wait = '0; inst_release = '0; inst_last = 0;
  endtask
  task automatic finish_exec(input int d, output int lat);
    lat = 0;
    while (!exec_start && lat < 100) begin tick(); lat++; end
    if (!exec_start) begin chk("start_timeout", 0, 1); return; end
    repeat (d) tick();
    exec_done = 1;
    tick();
    exec_done = 0;
    tick();
    chk("ready_after", inst_ready, 1);
  endtask
  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      exec_phase = 0;
      rel_due = 0;
    end else begin
      if (rel_due) begin
        chk("release", dep_release, pend.r);
        if (pend.last) prog_exp = 1;
        chk("prog_rel", prog_done, prog_exp);
        rel_due = 0;
      end else chk("no_release", dep_release, 0);
      if (exec_phase && exec_done) begin rel_due = 1; exec_phase = 0; end
      if (exec_start) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          pend = q.pop_front();
          chk("consume", dep_consume, pend.w);
          chk("exec_inst", exec_inst, pend.p);
        end
        exec_phase = 1;
      end else chk("no_consume", dep_consume, 0);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    chk("rst_ready", inst_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {exec_start, dep_consume, dep_release, prog_done}, 0);
    chk("rst_inst", exec_inst, 0);
    chk("rst_wait", wait_cycles, 0);
    reset = 0;
    tick();
    chk("ready_first", inst_ready, 1);
    send(3'b000, 3'b001, 0);
    finish_exec(3, n);
    chk("t1_start_lat", n, 1);
    chk("t1_wait", wait_cycles, wc_exp);
    set_cnt(1, 0);
    send(3'b010, 3'b000, 0);
    for (int i = 0; i < 10; i++) begin chk("t2_blocked", exec_start, 0); tick(); end
    set_cnt(1, 1);
    finish_exec(2, n);
    chk("t2_start_lat", n, 1);
    wc_exp += 10;
    chk("t2_wait", wait_cycles, wc_exp);
    set_cnt(0, 2);
    set_cnt(1, 32'hFFFF_FFFF);
    send(3'b011, 3'b000, 0);
    repeat (5) tick();
    chk("t3_blocked", {busy, exec_start}, 2'b10);
    set_cnt(1, 1);
    finish_exec(1, n);
    wc_exp += 5;
    chk("t3_wait", wait_cycles, wc_exp);
    set_cnt(2, 1);
    send(3'b100, 3'b100, 0);
    finish_exec(2, n);
    chk("t4_wait", wait_cycles, wc_exp);
    send(3'b000, 3'b111, 0);
    n = 0;
    while (!exec_start && n < 100) begin tick(); n++; end
    tick();
    reset = 1;
    tick();
    chk("t5_ready", inst_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_outs", {exec_start, dep_consume, dep_release, prog_done}, 0);
    chk("t5_inst", exec_inst, 0);
    chk("t5_wait", wait_cycles, 0);
    wc_exp = 0;
    reset = 0;
    tick();
    chk("t5_ready_after", inst_ready, 1);
    exec_done = 1;
    tick();
    exec_done = 0;
    chk("t5_done_ignored", {busy, dep_release}, 0);
    tick();
    chk("t5_idle", {busy, dep_release, inst_ready}, 1);
    send(3'b001, 3'b010, 0);
    finish_exec(1, n);
    send(3'b110, 3'b001, 0);
    finish_exec(1, n);
    send(3'b111, 3'b100, 1);
    finish_exec(1, n);
    repeat (3) tick();
    chk("prog_sticky", prog_done, 1);
    send(3'b000, 3'b000, 0);
    chk("prog_clear", prog_done, 0);
    finish_exec(1, n);
    chk("final_wait", wait_cycles, wc_exp);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
